// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Provides the state encoding, default watermark constants and circular index stepping.
package fifo_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_OPEN     = 1'b0,
        ST_THROTTLE = 1'b1
    } arb_state_e;

    localparam int DEF_HI_WM = 5;
    localparam int DEF_LO_WM = 2;
    localparam int DEF_BURST = 2;

    // Next index in circular order over n requesters.
    function automatic int circ_inc(input int idx, input int n);
        int nxt_v;
        if (idx >= n - 1) begin
            nxt_v = 0;
        end else begin
            nxt_v = idx + 1;
        end
        return nxt_v;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or after the start index.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_start,
    output logic            o_found,
    output logic [IW-1:0]   o_idx
);

    logic          w_found;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_cand;

    // Walk the requesters once, starting at i_start, keeping the first hit.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = i_start;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end else begin
                w_found = w_found;
            end
            w_cand = IW'(circ_inc(int'(w_cand), NREQ));
        end
    end

    assign o_found = w_found;
    assign o_idx   = w_idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers,
// with per-owner burst limit and HI/LO watermark throttling.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int CW    = 4,
    parameter int HI_WM = DEF_HI_WM,
    parameter int LO_WM = DEF_LO_WM,
    parameter int BURST = DEF_BURST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       data_in,
    output logic [NREQ-1:0]          ack,
    input  logic [CW-1:0]            fifo_words,
    output logic                     wr_en,
    output logic [DW-1:0]            fifo_data,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     throttled
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(BURST + 1);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic [GW-1:0]   r_owner;
    logic [BW-1:0]   r_burst_cnt;
    logic            r_wr_en;
    logic [DW-1:0]   r_fifo_data;
    logic [GW-1:0]   r_grant_id;
    logic            r_throttled;

    logic [GW-1:0]   w_start;
    logic [GW-1:0]   w_idx;
    logic            w_found;
    logic            w_hi;
    logic            w_lo;
    logic            w_grant;
    logic [NREQ-1:0] w_ack;
    logic [DW-1:0]   w_sel_data;

    assign w_hi = (fifo_words >= CW'(HI_WM));
    assign w_lo = (fifo_words <= CW'(LO_WM));

    // Stay on the current owner until its burst allowance is used up.
    always_comb begin
        if (r_burst_cnt < BW'(BURST)) begin
            w_start = r_owner;
        end else begin
            w_start = GW'(circ_inc(int'(r_owner), NREQ));
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (GW)
    ) u_rr_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // Next state and grant; the HI watermark check wins over any request.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_OPEN: begin
                if (w_hi) begin
                    w_state_nxt = ST_THROTTLE;
                end else begin
                    w_state_nxt = ST_OPEN;
                    w_grant     = w_found & rst_n;
                end
            end
            ST_THROTTLE: begin
                if (w_lo) begin
                    w_state_nxt = ST_OPEN;
                end else begin
                    w_state_nxt = ST_THROTTLE;
                end
            end
            default: begin
                w_state_nxt = ST_OPEN;
            end
        endcase
    end

    // One-hot acknowledge for the winner, data mux for the write port.
    always_comb begin
        if (w_grant) begin
            w_ack = {{(NREQ-1){1'b0}}, 1'b1} << w_idx;
        end else begin
            w_ack = '0;
        end
        w_sel_data = data_in[int'(w_idx)*DW +: DW];
    end

    assign ack = w_ack;

    // Registered write port, ownership bookkeeping and throttle flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_OPEN;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_wr_en     <= 1'b0;
            r_fifo_data <= '0;
            r_grant_id  <= '0;
            r_throttled <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_throttled <= (w_state_nxt == ST_THROTTLE);
            if (w_grant) begin
                r_wr_en     <= 1'b1;
                r_fifo_data <= w_sel_data;
                r_grant_id  <= w_idx;
                if (w_idx == r_owner) begin
                    if (r_burst_cnt < BW'(BURST)) begin
                        r_burst_cnt <= r_burst_cnt + BW'(1);
                    end else begin
                        r_burst_cnt <= r_burst_cnt;
                    end
                end else begin
                    r_owner     <= w_idx;
                    r_burst_cnt <= BW'(1);
                end
            end else begin
                r_wr_en <= 1'b0;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign fifo_data = r_fifo_data;
    assign grant_id  = r_grant_id;
    assign throttled = r_throttled;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, hand sequences,
// then random producers checked against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int HI    = 5;
    localparam int LO    = 2;
    localparam int BURST = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req;
    logic [31:0]     data_in;
    logic [3:0]      ack;
    logic [3:0]      fifo_words;
    logic            wr_en;
    logic [7:0]      fifo_data;
    logic [1:0]      grant_id;
    logic            throttled;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(
        .NREQ (NREQ), .DW (DW), .CW (CW),
        .HI_WM (HI), .LO_WM (LO), .BURST (BURST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .fifo_words (fifo_words),
        .wr_en      (wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .throttled  (throttled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] fw;
        logic [3:0] ack;
        logic       wr;
        logic [1:0] gid;
        logic       thr;
        logic [7:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] fw,
                       input logic [3:0] a, input logic w, input logic [1:0] g,
                       input logic t, input logic [7:0] d);
        vec_t v;
        v.rst_n = r; v.req = rq; v.fw = fw; v.ack = a;
        v.wr = w; v.gid = g; v.thr = t; v.data = d;
        tbl.push_back(v);
    endtask

    // Behavioural model state for the random phase
    int         m_owner;
    int         m_cnt;
    bit         m_thr;
    logic       m_wr;
    logic [7:0] m_data;
    logic [1:0] m_gid;
    bit         p_req[NREQ];
    logic [7:0] p_data[NREQ];
    int         fw;

    function automatic int model_pick();
        int start;
        if (m_thr || fw >= HI) return -1;
        start = (m_cnt < BURST) ? m_owner : (m_owner + 1) % NREQ;
        for (int k = 0; k < NREQ; k++) begin
            if (p_req[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        int seq [10];
        rst_n = 1'b0; req = 4'h0; data_in = 32'h0; fifo_words = 4'h0;
        @(posedge clk); #1;

        // Test 1: single requester streams
        add(1'b0, 4'hF, 4'd0, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) add(1'b1, 4'h1, 4'd0, 4'h1, 1'b1, 2'd0, 1'b0, 8'hA0);
        // Test 2: all request, burst of two each
        seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        add(1'b0, 4'hF, 4'd0, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++)
            add(1'b1, 4'hF, 4'd0, 4'(1 << seq[i]), 1'b1, 2'(seq[i]), 1'b0, 8'(8'hA0 + seq[i]));
        // Test 3: watermark hysteresis
        add(1'b0, 4'hF, 4'd0, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(1'b1, 4'h1, 4'd0, 4'h1, 1'b1, 2'd0, 1'b0, 8'hA0);
        add(1'b1, 4'h1, 4'd5, 4'h0, 1'b0, 2'd0, 1'b1, 8'hA0);
        add(1'b1, 4'h1, 4'd3, 4'h0, 1'b0, 2'd0, 1'b1, 8'hA0);
        add(1'b1, 4'h1, 4'd2, 4'h0, 1'b0, 2'd0, 1'b0, 8'hA0);
        add(1'b1, 4'h1, 4'd2, 4'h1, 1'b1, 2'd0, 1'b0, 8'hA0);
        // Test 6: request arrives with HI crossing
        add(1'b1, 4'h2, 4'd5, 4'h0, 1'b0, 2'd0, 1'b1, 8'hA0);
        add(1'b1, 4'h2, 4'd0, 4'h0, 1'b0, 2'd0, 1'b0, 8'hA0);
        add(1'b1, 4'h2, 4'd0, 4'h2, 1'b1, 2'd1, 1'b0, 8'hA1);
        // Test 4: owner drops mid-burst
        add(1'b0, 4'hF, 4'd0, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(1'b1, 4'h5, 4'd0, 4'h1, 1'b1, 2'd0, 1'b0, 8'hA0);
        add(1'b1, 4'h4, 4'd0, 4'h4, 1'b1, 2'd2, 1'b0, 8'hA2);
        add(1'b1, 4'h5, 4'd0, 4'h4, 1'b1, 2'd2, 1'b0, 8'hA2);
        add(1'b1, 4'h5, 4'd0, 4'h1, 1'b1, 2'd0, 1'b0, 8'hA0);
        // Test 5: reset during requester 3's burst
        add(1'b0, 4'hF, 4'd0, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++)
            add(1'b1, 4'hF, 4'd0, 4'(1 << seq[i]), 1'b1, 2'(seq[i]), 1'b0, 8'(8'hA0 + seq[i]));
        add(1'b0, 4'hF, 4'd0, 4'h0, 1'b0, 2'd0, 1'b0, 8'h00);
        add(1'b1, 4'hF, 4'd0, 4'h1, 1'b1, 2'd0, 1'b0, 8'hA0);

        data_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        foreach (tbl[n]) begin
            rst_n = tbl[n].rst_n; req = tbl[n].req; fifo_words = tbl[n].fw;
            #3;
            chk($sformatf("vec%0d_ack", n), 32'(ack), 32'(tbl[n].ack));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_wr_en", n), 32'(wr_en), 32'(tbl[n].wr));
            chk($sformatf("vec%0d_grant_id", n), 32'(grant_id), 32'(tbl[n].gid));
            chk($sformatf("vec%0d_throttled", n), 32'(throttled), 32'(tbl[n].thr));
            chk($sformatf("vec%0d_fifo_data", n), 32'(fifo_data), 32'(tbl[n].data));
        end

        // Fresh word on every ack appears on fifo_data one cycle later
        rst_n = 1'b1; fifo_words = 4'd0; req = 4'h1;
        for (int k = 0; k < 5; k++) begin
            data_in[7:0] = 8'(8'h10 + k);
            #3;
            chk("stream_ack", 32'(ack), 32'h1);
            @(posedge clk); #1;
            chk("stream_data", 32'(fifo_data), 32'(8'h10 + k));
            chk("stream_wr_en", 32'(wr_en), 32'h1);
        end

        // Random producers against the model
        rst_n = 1'b0; req = 4'h0; fifo_words = 4'd0;
        @(posedge clk); #1;
        m_owner = 0; m_cnt = 0; m_thr = 1'b0; m_wr = 1'b0; m_data = 8'h00; m_gid = 2'd0;
        fw = 0;
        for (int i = 0; i < NREQ; i++) begin
            p_req[i] = 1'b0; p_data[i] = 8'h00;
        end
        for (int c = 0; c < 3000; c++) begin
            bit r;
            int g;
            r = ($urandom_range(0, 99) != 0);
            rst_n = r;
            for (int i = 0; i < NREQ; i++) begin
                req[i] = p_req[i];
                data_in[i*8 +: 8] = p_data[i];
            end
            fifo_words = 4'(fw);
            g = r ? model_pick() : -1;
            #3;
            chk("rand_ack", 32'(ack), (g >= 0) ? (32'd1 << g) : 32'd0);
            @(posedge clk); #1;
            if (!r) begin
                m_owner = 0; m_cnt = 0; m_thr = 1'b0;
                m_wr = 1'b0; m_data = 8'h00; m_gid = 2'd0;
            end else begin
                if (g >= 0) begin
                    m_wr = 1'b1; m_data = p_data[g]; m_gid = 2'(g);
                    if (g == m_owner) begin
                        m_cnt = (m_cnt < BURST) ? m_cnt + 1 : BURST;
                    end else begin
                        m_owner = g; m_cnt = 1;
                    end
                end else begin
                    m_wr = 1'b0;
                end
                if (!m_thr && fw >= HI) m_thr = 1'b1;
                else if (m_thr && fw <= LO) m_thr = 1'b0;
            end
            chk("rand_wr_en", 32'(wr_en), 32'(m_wr));
            chk("rand_fifo_data", 32'(fifo_data), 32'(m_data));
            chk("rand_grant_id", 32'(grant_id), 32'(m_gid));
            chk("rand_throttled", 32'(throttled), 32'(m_thr));
            for (int i = 0; i < NREQ; i++) begin
                if (g == i) begin
                    p_req[i] = ($urandom_range(0, 3) != 0);
                    p_data[i] = 8'($urandom);
                end else if (!p_req[i] && $urandom_range(0, 2) == 0) begin
                    p_req[i] = 1'b1;
                    p_data[i] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 19) == 0) fw = $urandom_range(0, 9);
            else fw = fw + $urandom_range(0, 2) - 1;
            if (fw < 0) fw = 0;
            if (fw > 9) fw = 9;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
